videopll_lock_supervisor: RTL and testbench



---
 rtl/videopll_pkg.sv | 29 ++
 rtl/videopll_bit_sync.sv | 20 ++
 rtl/videopll_lock_supervisor.sv | 143 ++++++++++++++
 tb/tb_videopll_lock_supervisor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/videopll_pkg.sv
// Shared types and 50 MHz-reference defaults for the video PLL lock supervisor.
package videopll_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        FILTER,
        RELEASE,
        RUN
    } vpll_state_e;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_PLL_RST_CYCLES = 50;        // 1 us
    localparam int DEF_LOCK_TIMEOUT   = 5000000;   // 100 ms
    localparam int DEF_LOCK_FILTER    = 1024;
    localparam int DEF_NUM_DOMAINS    = 4;
    localparam int DEF_STAGGER        = 16;

    // Width that holds 0 .. largest_bound-1 for a counter shared by all states.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/videopll_bit_sync.sv
// Multi-flop level synchronizer for a single asynchronous control bit.
module videopll_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/videopll_lock_supervisor.sv
// Closes the loop around the video PLL: resets it, qualifies lock, then releases
// the per-domain resets in a staggered sequence.
//
// state     | meaning
// PLL_RESET | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK | waiting for locked_s, re-reset on LOCK_TIMEOUT
// FILTER    | counting LOCK_FILTER consecutive locked samples
// RELEASE   | clearing rst_out bits every STAGGER cycles
// RUN       | all domains out of reset, ready high
module videopll_lock_supervisor
    import videopll_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
    parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int STAGGER        = DEF_STAGGER
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready,
    output logic [7:0]             timeout_count,
    output logic [7:0]             unlock_count
);

    localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_FILTER,
                                     (NUM_DOMAINS - 1) * STAGGER + 1);
    localparam logic [CNT_W-1:0] TC_RST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_LOCK = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TC_FILT = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] TC_REL  = CNT_W'((NUM_DOMAINS - 1) * STAGGER);

    vpll_state_e            state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   locked_s;
    logic                   pll_rst_nxt;
    logic [NUM_DOMAINS-1:0] rst_out_nxt;
    logic                   ready_nxt;
    logic [7:0]             tcnt_nxt;
    logic [7:0]             ucnt_nxt;

    videopll_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= PLL_RESET;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            rst_out       <= '1;
            ready         <= 1'b0;
            timeout_count <= 8'd0;
            unlock_count  <= 8'd0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            pll_rst       <= pll_rst_nxt;
            rst_out       <= rst_out_nxt;
            ready         <= ready_nxt;
            timeout_count <= tcnt_nxt;
            unlock_count  <= ucnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        pll_rst_nxt = pll_rst;
        rst_out_nxt = rst_out;
        tcnt_nxt    = timeout_count;
        ucnt_nxt    = unlock_count;

        case (state)
            PLL_RESET: begin
                pll_rst_nxt = 1'b1;
                rst_out_nxt = '1;
                if (cnt == TC_RST) begin
                    state_nxt   = WAIT_LOCK;
                    cnt_nxt     = '0;
                    pll_rst_nxt = 1'b0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = FILTER;
                    cnt_nxt   = '0;
                end else if (cnt == TC_LOCK) begin
                    state_nxt   = PLL_RESET;
                    cnt_nxt     = '0;
                    pll_rst_nxt = 1'b1;
                    if (timeout_count != 8'hFF) tcnt_nxt = timeout_count + 8'd1;
                end
            end
            FILTER: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == TC_FILT) begin
                    state_nxt      = RELEASE;
                    cnt_nxt        = '0;
                    rst_out_nxt[0] = 1'b0;
                end
            end
            RELEASE, RUN: begin
                if (!locked_s) begin
                    state_nxt   = PLL_RESET;
                    cnt_nxt     = '0;
                    pll_rst_nxt = 1'b1;
                    rst_out_nxt = '1;
                    if (unlock_count != 8'hFF) ucnt_nxt = unlock_count + 8'd1;
                end else if (state == RUN) begin
                    cnt_nxt = cnt;
                end else if (cnt == TC_REL) begin
                    state_nxt = RUN;
                end else begin
                    // cnt_nxt is the number of edges since RELEASE entry
                    for (int i = 1; i < NUM_DOMAINS; i++) begin
                        if (cnt_nxt == CNT_W'(i * STAGGER)) rst_out_nxt[i] = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt   = PLL_RESET;
                cnt_nxt     = '0;
                pll_rst_nxt = 1'b1;
                rst_out_nxt = '1;
            end
        endcase

        ready_nxt = (state_nxt == RUN);
    end

endmodule

// File: tb/tb_videopll_lock_supervisor.sv
// Directed bench for the lock supervisor with short timing parameters.
module tb_videopll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic [3:0] rst_out;
    logic       ready;
    logic [7:0] timeout_count;
    logic [7:0] unlock_count;

    int checks = 0;
    int errors = 0;
    int t = 0;

    always #5 refclk = ~refclk;

    videopll_lock_supervisor #(
        .SYNC_STAGES    (2),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (32),
        .LOCK_FILTER    (8),
        .NUM_DOMAINS    (4),
        .STAGGER        (4)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .rst_out       (rst_out),
        .ready         (ready),
        .timeout_count (timeout_count),
        .unlock_count  (unlock_count)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge refclk);
        t++;
    endtask

    task automatic goto(input int k);
        while (t < k) step();
    endtask

    // t=0 is the negedge after the last reset edge; rst drops there.
    task automatic do_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        step();
        step();
        t = 0;
        chk_eq("rst_pll_rst", 32'(pll_rst), 32'd1);
        chk_eq("rst_rst_out", 32'(rst_out), 32'hF);
        chk_eq("rst_ready", 32'(ready), 32'd0);
        chk_eq("rst_tcnt", 32'(timeout_count), 32'd0);
        chk_eq("rst_ucnt", 32'(unlock_count), 32'd0);
        rst = 1'b0;
    endtask

    function automatic logic [3:0] rel_pattern(input int k, input int e);
        if (k < e)      return 4'hF;
        if (k < e + 4)  return 4'hE;
        if (k < e + 8)  return 4'hC;
        if (k < e + 12) return 4'h8;
        return 4'h0;
    endfunction

    initial begin
        // no lock: 4 high / 32 low pll_rst, timeout_count steps every 36 cycles
        do_reset();
        for (int k = 1; k <= 110; k++) begin
            goto(k);
            chk_eq("to_pll_rst", 32'(pll_rst), ((k % 36) < 4) ? 32'd1 : 32'd0);
            chk_eq("to_tcnt", 32'(timeout_count), 32'(k / 36));
            chk_eq("to_rst_out", 32'(rst_out), 32'hF);
            chk_eq("to_ready", 32'(ready), 32'd0);
        end

        // clean lock after first pll_rst fall: RELEASE at t=15, RUN at t=28
        do_reset();
        goto(4);
        chk_eq("lk_pll_rst_fall", 32'(pll_rst), 32'd0);
        pll_locked = 1'b1;
        for (int k = 5; k <= 32; k++) begin
            goto(k);
            chk_eq("lk_rst_out", 32'(rst_out), 32'(rel_pattern(k, 15)));
            chk_eq("lk_ready", 32'(ready), (k >= 28) ? 32'd1 : 32'd0);
            chk_eq("lk_pll_rst", 32'(pll_rst), 32'd0);
        end
        chk_eq("lk_tcnt", 32'(timeout_count), 32'd0);
        chk_eq("lk_ucnt", 32'(unlock_count), 32'd0);

        // one-cycle dropout on the 5th filter sample: RELEASE moves to t=21
        do_reset();
        goto(4);
        pll_locked = 1'b1;
        goto(9);
        pll_locked = 1'b0;
        goto(10);
        pll_locked = 1'b1;
        for (int k = 11; k <= 36; k++) begin
            goto(k);
            chk_eq("gl_rst_out", 32'(rst_out), 32'(rel_pattern(k, 21)));
            chk_eq("gl_ready", 32'(ready), (k >= 34) ? 32'd1 : 32'd0);
        end

        // lock loss in RUN: seen at t=43, then the sequence repeats
        goto(40);
        pll_locked = 1'b0;
        goto(42);
        chk_eq("ul_before_ready", 32'(ready), 32'd1);
        chk_eq("ul_before_rst_out", 32'(rst_out), 32'h0);
        goto(43);
        chk_eq("ul_rst_out", 32'(rst_out), 32'hF);
        chk_eq("ul_ready", 32'(ready), 32'd0);
        chk_eq("ul_pll_rst", 32'(pll_rst), 32'd1);
        chk_eq("ul_ucnt", 32'(unlock_count), 32'd1);
        goto(46);
        chk_eq("ul_pll_rst_hold", 32'(pll_rst), 32'd1);
        goto(47);
        chk_eq("ul_pll_rst_fall", 32'(pll_rst), 32'd0);
        pll_locked = 1'b1;
        goto(57);
        chk_eq("ul_relock_f", 32'(rst_out), 32'hF);
        goto(58);
        chk_eq("ul_relock_e", 32'(rst_out), 32'hE);
        goto(70);
        chk_eq("ul_relock_rdy0", 32'(ready), 32'd0);
        goto(71);
        chk_eq("ul_relock_rdy1", 32'(ready), 32'd1);
        chk_eq("ul_ucnt_keep", 32'(unlock_count), 32'd1);
        chk_eq("ul_tcnt_keep", 32'(timeout_count), 32'd0);

        // lock arriving on the timeout cycle wins over the timeout
        do_reset();
        goto(33);
        pll_locked = 1'b1;
        goto(36);
        chk_eq("tie_pll_rst", 32'(pll_rst), 32'd0);
        chk_eq("tie_tcnt", 32'(timeout_count), 32'd0);
        goto(43);
        chk_eq("tie_rst_out_f", 32'(rst_out), 32'hF);
        goto(44);
        chk_eq("tie_rst_out_e", 32'(rst_out), 32'hE);

        // 300 timeouts saturate at 255
        do_reset();
        goto(36 * 255 - 1);
        chk_eq("sat_254", 32'(timeout_count), 32'd254);
        goto(36 * 255);
        chk_eq("sat_255", 32'(timeout_count), 32'd255);
        goto(36 * 256);
        chk_eq("sat_nowrap", 32'(timeout_count), 32'd255);
        goto(36 * 300 + 5);
        chk_eq("sat_300", 32'(timeout_count), 32'd255);

        // rst mid-RELEASE with rst_out=C overrides on the next edge
        goto(36 * 301 + 4);
        chk_eq("mr_pll_rst_fall", 32'(pll_rst), 32'd0);
        pll_locked = 1'b1;
        goto(36 * 301 + 4 + 15);
        chk_eq("mr_rst_out_c", 32'(rst_out), 32'hC);
        chk_eq("mr_tcnt_255", 32'(timeout_count), 32'd255);
        rst = 1'b1;
        step();
        chk_eq("mr_rst_out", 32'(rst_out), 32'hF);
        chk_eq("mr_pll_rst", 32'(pll_rst), 32'd1);
        chk_eq("mr_ready", 32'(ready), 32'd0);
        chk_eq("mr_tcnt", 32'(timeout_count), 32'd0);
        chk_eq("mr_ucnt", 32'(unlock_count), 32'd0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
